// File: rtl/vartheta_inv_seq.sv
// Inverse vartheta, one column per cycle: column k of the captured word is
// rotated left by PC/PB/PA/0 (k=0..3) into the registered result y.
module vartheta_inv_seq #(
    parameter int unsigned BLOCK_SIZE  = 128,
    parameter int unsigned SIDE_SIZE   = BLOCK_SIZE / 2,
    parameter int unsigned COLUMN_SIZE = SIDE_SIZE / 4,
    parameter int unsigned PA          = 1,
    parameter int unsigned PB          = 3,
    parameter int unsigned PC          = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:SIDE_SIZE-1] x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:SIDE_SIZE-1] y,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_COL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [0:SIDE_SIZE-1]   x_q, x_d;
    logic [0:SIDE_SIZE-1]   y_q, y_d;
    logic                   accept;
    int unsigned            base;
    int unsigned            amt;
    logic [0:COLUMN_SIZE-1] col_in;
    logic [0:COLUMN_SIZE-1] col_out;

    // Index 0 is the MSB, so a left rotation pulls bits toward index 0.
    function automatic logic [0:COLUMN_SIZE-1] rotl_col(
        input logic [0:COLUMN_SIZE-1] c,
        input int unsigned            n
    );
        logic [0:COLUMN_SIZE-1] r;
        r = '0;
        for (int unsigned i = 0; i < COLUMN_SIZE; i++) begin
            r[i] = c[(i + n) % COLUMN_SIZE];
        end
        return r;
    endfunction

    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        accept    = in_valid && in_ready;
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        y         = y_q;
    end

    always_comb begin
        base = 32'(cnt_q) * COLUMN_SIZE;
        case (cnt_q)
            2'd0:    amt = PC;
            2'd1:    amt = PB;
            2'd2:    amt = PA;
            default: amt = 0;
        endcase
        col_in  = x_q[base +: COLUMN_SIZE];
        col_out = rotl_col(col_in, amt);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    x_d     = x;
                    cnt_d   = 2'd0;
                    state_d = ST_COL;
                end
            end
            ST_COL: begin
                y_d[base +: COLUMN_SIZE] = col_out;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Handing off the result and taking the next word share one edge.
                if (out_ready) begin
                    if (in_valid) begin
                        x_d     = x;
                        cnt_d   = 2'd0;
                        state_d = ST_COL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

endmodule

// File: tb/tb_vartheta_inv_seq.sv
// Randomized self-checking bench for vartheta_inv_seq against an arithmetic
// column-rotation model (default 64-bit side, 16-bit columns).
module tb_vartheta_inv_seq;

    localparam int unsigned W    = 64;
    localparam int unsigned ROTA = 1;
    localparam int unsigned ROTB = 3;
    localparam int unsigned ROTC = 13;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [0:W-1] x;
    logic         out_valid;
    logic         out_ready;
    logic [0:W-1] y;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vartheta_inv_seq #(
        .BLOCK_SIZE (128),
        .PA         (ROTA),
        .PB         (ROTB),
        .PC         (ROTC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rotl16(input logic [15:0] v, input int unsigned n);
        logic [31:0] d;
        int unsigned s;
        d = {v, v};
        s = n % 16;
        return d[31-s -: 16];
    endfunction

    function automatic int unsigned col_amt(input int unsigned k);
        case (k)
            0:       return ROTC;
            1:       return ROTB;
            2:       return ROTA;
            default: return 0;
        endcase
    endfunction

    // Column 0 is the most significant 16 bits.
    function automatic logic [63:0] model_inv(input logic [63:0] v);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            r[63-16*k -: 16] = rotl16(v[63-16*k -: 16], col_amt(k));
        return r;
    endfunction

    function automatic logic [63:0] model_fwd(input logic [63:0] v);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            r[63-16*k -: 16] = rotl16(v[63-16*k -: 16], (16 - col_amt(k)) % 16);
        return r;
    endfunction

    // Called just after a falling edge; returns just after a falling edge.
    task automatic do_word(input logic [63:0] w, input logic [63:0] exp_y, input int unsigned hold);
        int n;
        x = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        x         = {$urandom, $urandom};
        out_ready = (hold == 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
            x = {$urandom, $urandom};
        end
        check("latency", 64'(n), 64'd4);
        check("y", y, exp_y);
        check("fwd_y", model_fwd(y), w);
        repeat (hold) begin
            x = {$urandom, $urandom};
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_y", y, exp_y);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", 64'(out_valid), 64'd0);
        check("release_busy", 64'(busy), 64'd0);
    endtask

    task automatic stream(input int nwords);
        logic [63:0] q[$];
        logic [63:0] cur;
        logic        acc_now;
        int acc, got, last, cyc;
        acc = 0; got = 0; last = -1; cyc = 0;
        out_ready = 1'b1;
        cur = {$urandom, $urandom};
        x = cur;
        in_valid = 1'b1;
        while (got < nwords && cyc < nwords * 5 + 50) begin
            if (out_valid) begin
                if (q.size() > 0) begin
                    check("stream_y", y, model_inv(q.pop_front()));
                end else begin
                    check("stream_spurious", 64'(out_valid), 64'd0);
                end
                if (last >= 0) check("stream_gap", 64'(cyc - last), 64'd5);
                last = cyc;
                got++;
            end
            acc_now = in_ready && in_valid;
            if (acc_now) q.push_back(cur);
            @(negedge clk);
            cyc++;
            if (acc_now) begin
                acc++;
                if (acc == nwords) begin
                    in_valid = 1'b0;
                end else begin
                    cur = {$urandom, $urandom};
                    x = cur;
                end
            end
        end
        check("stream_count", 64'(got), 64'(nwords));
        @(negedge clk);
        check("stream_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov_seen;
        logic [63:0] w;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_y", y, 64'd0);
        rst = 1'b0;
        do_word(64'h0004_1000_4000_8000, 64'h8000_8000_8000_8000, 0);

        // Abort mid-word with cnt=2, reset asserted away from any clock edge.
        x = 64'h0004_1000_4000_8000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_y", y, 64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        ov_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        check("arst_no_stale", 64'(ov_seen), 64'd0);
        w = {$urandom, $urandom};
        do_word(w, model_inv(w), 0);

        do_word(64'h0001_0001_0001_0001, 64'h2000_0008_0002_0001, 0);
        do_word('1, '1, 0);
        do_word('0, '0, 0);
        w = {$urandom, $urandom};
        do_word(w, model_inv(w), 10);
        repeat (20) begin
            w = {$urandom, $urandom};
            do_word(w, model_inv(w), $urandom_range(0, 2));
        end
        stream(100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
